// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, grant owner,
// and the registered memory command payload.
package mem_arb_defs;

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TIMER_W  = 16;

    localparam logic [3:0] WEN_READ = 4'b0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } mem_cmd_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter for one memory access; tc_c flags the last allowed BUSY cycle.
module arb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned WIDTH          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc_c
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign tc_c = (count_q == TERMINAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: data first, fetch forced through
// after MAX_D_STREAK data grants, wait-state timeout reported as a bus error.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wen_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        m_req_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wen_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ack_i,
    output logic        bus_err_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_q, state_d;
    grant_t              grant_q, grant_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                m_req_q, m_req_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                bus_err_q, bus_err_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                busy_c;
    logic                tc_c;

    assign busy_c = (state_q == BUSY_I) || (state_q == BUSY_D);

    arb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .WIDTH          (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!busy_c),
        .load     (1'b0),
        .load_val ('0),
        .en       (busy_c && !m_ack_i),
        .tc_c     (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_I;
            streak_q   <= '0;
            cmd_q      <= '0;
            m_req_q    <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            streak_q   <= streak_d;
            cmd_q      <= cmd_d;
            m_req_q    <= m_req_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        streak_d   = streak_q;
        cmd_d      = cmd_q;
        cmd_d.wen  = WEN_READ;
        m_req_d    = 1'b0;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        bus_err_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (!if_req_i) begin
                    streak_d = '0;
                end
                if (d_req_i && !(if_req_i && streak_q >= STREAK_MAX)) begin
                    state_d     = BUSY_D;
                    grant_d     = GRANT_D;
                    m_req_d     = 1'b1;
                    cmd_d.addr  = d_addr_i;
                    cmd_d.wdata = d_wdata_i;
                    cmd_d.wen   = d_wen_i;
                    if (if_req_i) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (if_req_i) begin
                    state_d     = BUSY_I;
                    grant_d     = GRANT_I;
                    m_req_d     = 1'b1;
                    cmd_d.addr  = if_addr_i;
                    cmd_d.wdata = '0;
                    streak_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack on the terminal cycle wins over the timeout.
                if (m_ack_i || tc_c) begin
                    state_d   = RESP;
                    bus_err_d = !m_ack_i;
                    if (grant_q == GRANT_I) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = m_ack_i ? m_rdata_i : '0;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = (m_ack_i && cmd_q.wen == WEN_READ) ? m_rdata_i : '0;
                    end
                end else begin
                    m_req_d   = 1'b1;
                    cmd_d.wen = cmd_q.wen;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata_o = if_rdata_q;
    assign if_ready_o = if_ready_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_ready_o  = d_ready_q;
    assign m_req_o    = m_req_q;
    assign m_addr_o   = cmd_q.addr;
    assign m_wdata_o  = cmd_q.wdata;
    assign m_wen_o    = cmd_q.wen;
    assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i, d_req_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
    logic [3:0]  d_wen_i;
    logic [31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
    logic        if_ready_o, d_ready_o, m_req_o, bus_err_o;
    logic [3:0]  m_wen_o;
    logic [31:0] m_rdata_i = '0;
    logic        m_ack_i = 1'b0;

    // Directed (t_) and random (r_) requester drivers, muxed by drv_en.
    logic        drv_en = 1'b0, new_en = 1'b0;
    logic        t_if_req = 1'b0, t_d_req = 1'b0, r_if_req = 1'b0, r_d_req = 1'b0;
    logic [31:0] t_if_addr = '0, t_d_addr = '0, t_d_wdata = '0;
    logic [31:0] r_if_addr = '0, r_d_addr = '0, r_d_wdata = '0;
    logic [3:0]  t_d_wen = '0, r_d_wen = '0;

    assign if_req_i  = drv_en ? r_if_req  : t_if_req;
    assign if_addr_i = drv_en ? r_if_addr : t_if_addr;
    assign d_req_i   = drv_en ? r_d_req   : t_d_req;
    assign d_addr_i  = drv_en ? r_d_addr  : t_d_addr;
    assign d_wdata_i = drv_en ? r_d_wdata : t_d_wdata;
    assign d_wen_i   = drv_en ? r_d_wen   : t_d_wen;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wen_i(d_wen_i),
        .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wen_o(m_wen_o),
        .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory responder: acks after a chosen number of wait cycles; stray acks when idle.
    int          fixed_wait = 0;
    logic [31:0] fixed_rdata = '0;
    logic        wait_rand = 1'b0;
    logic        mem_active = 1'b0;
    int          mem_cnt = 0, mem_target = 0;

    always @(negedge clk) begin
        if (m_req_o) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt    = 0;
                mem_target = wait_rand ? int'($urandom_range(0, 9)) : fixed_wait;
            end
            if (mem_cnt == mem_target) begin
                m_ack_i   = 1'b1;
                m_rdata_i = wait_rand ? $urandom : fixed_rdata;
            end else begin
                m_ack_i   = 1'b0;
                m_rdata_i = $urandom;
            end
            mem_cnt++;
        end else begin
            mem_active = 1'b0;
            m_rdata_i  = $urandom;
            m_ack_i    = wait_rand && ($urandom_range(0, 7) == 0);
        end
    end

    // Random requesters: raise at random, hold until ready, then drop or chain a new one.
    always @(negedge clk) begin
        if (drv_en && rst_n) begin
            if (r_if_req) begin
                if (if_ready_o) begin
                    if (new_en && $urandom_range(0, 1) == 1) r_if_addr = $urandom & 32'hFFFF_FFFC;
                    else r_if_req = 1'b0;
                end
            end else if (new_en && $urandom_range(0, 2) == 0) begin
                r_if_req  = 1'b1;
                r_if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (r_d_req) begin
                if (d_ready_o) begin
                    if (new_en && $urandom_range(0, 1) == 1) begin
                        r_d_addr  = $urandom;
                        r_d_wdata = $urandom;
                        r_d_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
                    end else r_d_req = 1'b0;
                end
            end else if (new_en && $urandom_range(0, 1) == 0) begin
                r_d_req   = 1'b1;
                r_d_addr  = $urandom;
                r_d_wdata = $urandom;
                r_d_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            end
        end
    end

    // Transaction-level model: one access in flight, then a single response cycle.
    bit          md_inflight = 0, md_resp = 0, md_own_d = 0;
    int          md_waited = 0, md_streak = 0;
    logic [3:0]  md_wen = '0;
    logic [31:0] md_rd;
    bit          e_mreq = 0, e_ir = 0, e_dr = 0, e_err = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_ird = '0, e_drd = '0;
    logic [3:0]  e_wen = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_inflight = 0; md_resp = 0; md_streak = 0; md_waited = 0;
            e_mreq = 0; e_ir = 0; e_dr = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0; e_wen = '0;
        end else begin
            e_ir = 0; e_dr = 0; e_err = 0;
            if (md_resp) begin
                md_resp = 0;
            end else if (md_inflight) begin
                md_waited++;
                if (m_ack_i || md_waited == TMO) begin
                    md_inflight = 0;
                    md_resp     = 1;
                    e_mreq      = 0;
                    e_wen       = '0;
                    e_err       = !m_ack_i;
                    md_rd       = (m_ack_i && !(md_own_d && md_wen != 4'b0)) ? m_rdata_i : 32'h0;
                    if (md_own_d) begin e_dr = 1; e_drd = md_rd; end
                    else begin e_ir = 1; e_ird = md_rd; end
                end
            end else begin
                if (!if_req_i) md_streak = 0;
                if (d_req_i && !(if_req_i && md_streak == MAXS)) begin
                    md_own_d = 1; md_wen = d_wen_i;
                    e_addr = d_addr_i; e_wdata = d_wdata_i; e_wen = d_wen_i;
                    if (if_req_i) md_streak = (md_streak < MAXS) ? md_streak + 1 : MAXS;
                    md_inflight = 1; md_waited = 0; e_mreq = 1;
                end else if (if_req_i) begin
                    md_own_d = 0; md_wen = '0;
                    e_addr = if_addr_i; e_wdata = '0; e_wen = '0;
                    md_streak = 0;
                    md_inflight = 1; md_waited = 0; e_mreq = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("m_req", m_req_o, e_mreq);
            chk("m_wen", m_wen_o, e_wen);
            if (e_mreq) begin
                chk("m_addr", m_addr_o, e_addr);
                chk("m_wdata", m_wdata_o, e_wdata);
            end
            chk("if_ready", if_ready_o, e_ir);
            chk("d_ready", d_ready_o, e_dr);
            chk("bus_err", bus_err_o, e_err);
            chk("if_rdata", if_rdata_o, e_ird);
            chk("d_rdata", d_rdata_o, e_drd);
        end
    end

    int  nd, nb;
    bit  seen;

    initial begin
        #23;
        chk("rst_mreq", m_req_o, 0);
        chk("rst_ready", {if_ready_o, d_ready_o, bus_err_o}, 0);
        chk("rst_rdata", if_rdata_o | d_rdata_o | m_addr_o | m_wdata_o, 0);
        tick(); rst_n = 1'b1; chk_en = 1'b1;
        tick(); tick();

        // Fetch alone, zero wait.
        fixed_wait = 0; fixed_rdata = 32'h0000_0093;
        t_if_addr = 32'h10; t_if_req = 1'b1;
        tick();
        chk("fa_mreq", m_req_o, 1); chk("fa_wen", m_wen_o, 0); chk("fa_addr", m_addr_o, 32'h10);
        tick();
        chk("fa_ready", if_ready_o, 1); chk("fa_rdata", if_rdata_o, 32'h93);
        chk("fa_err", bus_err_o, 0); chk("fa_mreq_off", m_req_o, 0);
        t_if_req = 1'b0;
        tick(); chk("fa_ready_pulse", if_ready_o, 0);

        // Simultaneous: data first, fetch at the next IDLE.
        fixed_rdata = 32'hCAFE_0001;
        t_if_addr = 32'h20; t_if_req = 1'b1; t_d_addr = 32'h100; t_d_wen = 4'b0; t_d_req = 1'b1;
        tick(); chk("sim_data_first", m_addr_o, 32'h100);
        tick(); chk("sim_d_ready", d_ready_o, 1); chk("sim_d_rdata", d_rdata_o, 32'hCAFE_0001);
        chk("sim_no_if_ready", if_ready_o, 0);
        t_d_req = 1'b0;
        tick(); tick(); chk("sim_fetch_addr", m_addr_o, 32'h20); chk("sim_fetch_req", m_req_o, 1);
        tick(); chk("sim_if_ready", if_ready_o, 1); chk("sim_if_rdata", if_rdata_o, 32'hCAFE_0001);
        t_if_req = 1'b0; tick();

        // Starvation: two rounds with if_req held, each 4 data grants then the fetch.
        fixed_rdata = 32'h1357_9BDF;
        t_if_addr = 32'h40; t_if_req = 1'b1; t_d_addr = 32'h400; t_d_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            nd = 0; seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                if (d_ready_o) begin nd++; t_d_addr = t_d_addr + 32'd4; end
                if (if_ready_o) begin seen = 1; t_if_addr = t_if_addr + 32'd4; end
            end
            chk("starve_dcount", nd, MAXS); chk("starve_fetch", seen, 1);
        end
        t_if_req = 1'b0; t_d_req = 1'b0; tick();

        // Timeout, then a normal access.
        fixed_wait = 1000;
        t_d_addr = 32'h300; t_d_wen = 4'b0; t_d_req = 1'b1;
        nb = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (m_req_o) nb++;
            if (d_ready_o) seen = 1;
        end
        chk("tmo_busy_cycles", nb, TMO); chk("tmo_ready", seen, 1);
        chk("tmo_err", bus_err_o, 1); chk("tmo_rdata", d_rdata_o, 0);
        t_d_req = 1'b0; tick(); chk("tmo_err_pulse", bus_err_o, 0);
        fixed_wait = 0; fixed_rdata = 32'h0BAD_F00D;
        t_d_addr = 32'h304; t_d_req = 1'b1;
        tick(); tick();
        chk("rec_ready", d_ready_o, 1); chk("rec_err", bus_err_o, 0); chk("rec_rdata", d_rdata_o, 32'h0BAD_F00D);
        t_d_req = 1'b0; tick();

        // Write with wait states.
        fixed_wait = 2; fixed_rdata = 32'h5555_AAAA;
        t_d_addr = 32'h200; t_d_wdata = 32'hDEAD_BEEF; t_d_wen = 4'b0011; t_d_req = 1'b1;
        nb = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (m_req_o) begin
                nb++;
                chk("wr_wen", m_wen_o, 4'b0011); chk("wr_addr", m_addr_o, 32'h200);
                chk("wr_wdata", m_wdata_o, 32'hDEAD_BEEF);
            end
            if (d_ready_o) seen = 1;
        end
        chk("wr_busy_cycles", nb, 3); chk("wr_ready", seen, 1);
        chk("wr_rdata", d_rdata_o, 0); chk("wr_err", bus_err_o, 0);
        t_d_req = 1'b0; t_d_wen = 4'b0; tick();

        // Randomized traffic, then drain.
        wait_rand = 1'b1; drv_en = 1'b1; new_en = 1'b1;
        repeat (3000) tick();
        new_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (!r_if_req && !r_d_req) seen = 1;
        end
        chk("drain", seen, 1);
        tick(); tick();
        drv_en = 1'b0; wait_rand = 1'b0;
        tick(); tick();

        // Reset during the 4th data access of a streak.
        fixed_wait = 0;
        t_if_addr = 32'h80; t_if_req = 1'b1; t_d_addr = 32'h800; t_d_wen = 4'b0; t_d_req = 1'b1;
        nd = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (d_ready_o) begin
                nd++; t_d_addr = t_d_addr + 32'd4;
                if (nd == 3) fixed_wait = 1000;
            end else if (nd == 3 && m_req_o) seen = 1;
        end
        chk("rm_in_busy", seen, 1); chk("rm_data_addr", m_addr_o, 32'h80C);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_mreq_drop", m_req_o, 0);
        chk("rm_outs", {if_ready_o, d_ready_o, bus_err_o, m_wen_o}, 0);
        t_if_req = 1'b0; t_d_req = 1'b0; fixed_wait = 0;
        tick(); tick(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rm_idle_req", m_req_o, 0); chk("rm_no_ready", {if_ready_o, d_ready_o}, 0);
        end
        t_if_addr = 32'h90; t_if_req = 1'b1; t_d_addr = 32'h900; t_d_req = 1'b1;
        tick(); chk("rm_streak_clear", m_addr_o, 32'h900);
        tick(); chk("rm_after_ready", d_ready_o, 1);
        t_d_req = 1'b0;
        tick(); tick(); tick(); chk("rm_fetch_done", if_ready_o, 1);
        t_if_req = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between two requesters: the IF-stage instruction fetch port and the MEM-stage data port.
- Sits between cpu_top's i_mem/d_mem interfaces and the external memory.
- Provides request/ready handshakes, so each pipeline stage stalls while its request is pending.
- Data has priority, bounded by an anti-starvation limit; a wait-state timeout raises a bus error.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through (1..15)
TIMEOUT_CYCLES, 255, maximum cycles waiting for m_ack before abort (1..65535)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held high with stable if_addr_i until if_ready_o
if_addr_i  in  32  fetch address (word aligned)
if_rdata_o  out  32  fetched instruction, valid when if_ready_o
if_ready_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request; held with stable addr/wdata/wen until d_ready_o
d_addr_i  in  32  data address
d_wdata_i  in  32  store data
d_wen_i  in  4  byte enables; 4'b0000 = read, nonzero = write
d_rdata_o  out  32  load data, valid when d_ready_o (0 for writes)
d_ready_o  out  1  one-cycle completion pulse for data
m_req_o  out  1  memory request, held until m_ack_i or timeout
m_addr_o  out  32  memory address
m_wdata_o  out  32  memory write data
m_wen_o  out  4  memory byte enables (0 during fetch)
m_rdata_i  in  32  memory read data, valid with m_ack_i
m_ack_i  in  1  one-cycle memory completion pulse
bus_err_o  out  1  one-cycle pulse on timeout abort, coincident with the ready pulse

Behaviour:
- Reset: every output is 0. State is IDLE, streak counter 0, timer 0. An asserted rst_n mid-access drops m_req_o immediately (asynchronous), and no ready pulse follows.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: samples requests.
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both pending: BUSY_D, unless streak == MAX_D_STREAK, in which case BUSY_I.
  - Neither: stay in IDLE.
- Streak counter:
  - Increments on each BUSY_D entry while if_req_i is high.
  - Clears on BUSY_I entry, and on any IDLE cycle with if_req_i low.
  - Saturates at MAX_D_STREAK.
- BUSY_I / BUSY_D:
  - m_req_o = 1, with m_addr_o, m_wdata_o and m_wen_o registered from the granted requester at entry. They stay stable for the whole access.
  - On m_ack_i: latch m_rdata_i (d_rdata latches 0 if the access is a write) and go to RESP.
- Timeout: the timer counts BUSY cycles without ack. When it reaches TIMEOUT_CYCLES:
  - drop m_req_o;
  - latch rdata 0;
  - set a pending-error flag;
  - go to RESP.
- RESP:
  - Exactly one cycle.
  - Pulses the granted ready (if_ready_o or d_ready_o), with bus_err_o if the error flag is set.
  - Requests are ignored; next state is IDLE.
  - m_req_o = 0, m_wen_o = 0.
- Latency: a request sampled in IDLE at cycle 0 with a zero-wait memory (ack during the first BUSY cycle, cycle 1) gives ready at cycle 2 and IDLE at cycle 3. Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles plus wait states.
- m_ack_i outside BUSY: ignored.
- An ack arriving in the same cycle the timer reaches its limit counts as success; no error.
- A requester deasserting req before ready is a protocol violation; the access still completes and its ready pulse is still emitted.
- Only one ready pulse ever occurs per cycle. rdata outputs hold their last value until the next ready pulse.

Decomposition:
- Shared package/header mem_arb_defs: the FSM state encodings (2-bit: IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3), WEN_READ=4'b0000, and the GRANT_I/GRANT_D encoding.
- One sub-module, arb_wait_timer: a loadable up-counter with clear, enable and terminal-count output, parameterised by TIMEOUT_CYCLES. The FSM, streak counter and output registers stay in mem_port_arbiter.

Test Plan:
- Fetch alone: if_req at 0x0000_0010, memory acks in the first BUSY cycle with 0x0000_0093 -> m_req high for 1 cycle, m_wen=0, if_ready pulses 2 cycles after grant with if_rdata=0x0000_0093, bus_err=0.
- Simultaneous requests: if_req 0x20, d_req read 0x100 -> data served first (d_ready, d_rdata=m_rdata), then fetch is granted at the next IDLE.
- Starvation: if_req held high while d_req is re-asserted continuously, MAX_D_STREAK=4 -> exactly 4 data accesses, then the 5th grant is BUSY_I; the streak clears afterward.
- Write with wait states: d_req, d_wen=4'b0011, addr 0x200, wdata 0xDEAD_BEEF, ack after 3 cycles -> m_wen=4'b0011 and m_addr/m_wdata stable for all 3 cycles, d_ready pulses with d_rdata=0.
- Timeout: TIMEOUT_CYCLES=8, no ack -> m_req drops after 8 BUSY cycles, d_ready and bus_err pulse together, rdata=0; a subsequent access completes normally.
- Reset mid-access: assert rst_n low during BUSY_D -> m_req_o goes to 0 immediately, no ready pulse; after release the FSM is in IDLE and the streak is 0.
